pong_game_ctrl: RTL and testbench

Game-level sequencer for the Pong ball-movement datapath. It owns the ball direction bits, decides when the ball is re-centred or allowed to move, and detects wall bounces, paddle hits and misses once per frame. It keeps score and runs the serve / play / point / game-over flow. It sits between the VGA frame timing and the ball-position registers, and feeds score and state to the display logic.

---
 rtl/pong_pkg.sv | 57 +++++
 rtl/pong_collide.sv | 53 +++++
 rtl/pong_game_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and geometry defaults for the Pong game controller.
// State encoding is fixed because the state value is exported for display/debug.
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam int COORD_W         = 10;
  localparam int SCORE_W         = 4;
  localparam int FRAME_CNT_W     = 8;

  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BALL_SIZE   = 8;
  localparam int DEF_PADDLE_L_X  = 16;
  localparam int DEF_PADDLE_R_X  = 624;
  localparam int DEF_PADDLE_H    = 64;
  localparam int DEF_WIN_SCORE   = 9;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_PAUSE_FRAMES = 90;

  typedef struct packed {
    logic ball_reset;
    logic ball_move_en;
    logic game_over;
  } ctrl_t;

  // Datapath control levels that go with each state; registered alongside the state.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c.ball_reset   = 1'b1;
    c.ball_move_en = 1'b0;
    c.game_over    = 1'b0;
    case (s)
      S_PLAY: begin
        c.ball_reset   = 1'b0;
        c.ball_move_en = 1'b1;
      end
      S_POINT: begin
        c.ball_reset   = 1'b0;
      end
      S_GAME_OVER: begin
        c.game_over    = 1'b1;
      end
      default: begin
        c.ball_reset   = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pong_collide.sv
// Combinational per-frame collision classifier: wall bounces, paddle hits and misses.
// Everything is widened to 11 bits so sums of coordinates and sizes cannot wrap.
module pong_collide
  import pong_pkg::*;
#(
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int BALL_SIZE  = DEF_BALL_SIZE,
  parameter int PADDLE_L_X = DEF_PADDLE_L_X,
  parameter int PADDLE_R_X = DEF_PADDLE_R_X,
  parameter int PADDLE_H   = DEF_PADDLE_H
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] paddle_l_y,
  input  logic [COORD_W-1:0] paddle_r_y,
  input  logic               dir_x,
  input  logic               dir_y,
  output logic               hit_l,
  output logic               hit_r,
  output logic               miss_l,
  output logic               miss_r,
  output logic               bounce_top,
  output logic               bounce_bot
);

  localparam logic [10:0] SW  = 11'(SCREEN_W);
  localparam logic [10:0] SH  = 11'(SCREEN_H);
  localparam logic [10:0] BS  = 11'(BALL_SIZE);
  localparam logic [10:0] PLX = 11'(PADDLE_L_X);
  localparam logic [10:0] PRX = 11'(PADDLE_R_X);
  localparam logic [10:0] PH  = 11'(PADDLE_H);

  logic [10:0] bx, by, pl, pr;
  logic        overlap_l, overlap_r;

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign pl = {1'b0, paddle_l_y};
  assign pr = {1'b0, paddle_r_y};

  // Any vertical overlap between the ball and the paddle face counts as contact.
  assign overlap_l = (by + BS > pl) && (by < pl + PH);
  assign overlap_r = (by + BS > pr) && (by < pr + PH);

  assign hit_l      = ~dir_x & (bx <= PLX) & overlap_l;
  assign hit_r      =  dir_x & (bx + BS >= PRX) & overlap_r;
  assign miss_l     = ~dir_x & (bx == 11'd0) & ~hit_l;
  assign miss_r     =  dir_x & (bx >= SW - BS) & ~hit_r;
  assign bounce_top = ~dir_y & (by == 11'd0);
  assign bounce_bot =  dir_y & (by >= SH - BS);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve / play / point / game-over flow, ball direction and scoring.
// Decisions taken on a frame_tick become visible one cycle later, ready for the next tick.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_L_X   = DEF_PADDLE_L_X,
  parameter int PADDLE_R_X   = DEF_PADDLE_R_X,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] paddle_l_y,
  input  logic [COORD_W-1:0] paddle_r_y,
  output logic               ball_reset,
  output logic               ball_move_en,
  output logic               ball_dir_x,
  output logic               ball_dir_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam logic [SCORE_W-1:0]     WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] PAUSE_LAST = FRAME_CNT_W'(PAUSE_FRAMES - 1);

  state_t                 cur;
  ctrl_t                  ctrl;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   scorer;
  logic                   hit_l, hit_r, miss_l, miss_r, bounce_top, bounce_bot;

  pong_collide #(
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .BALL_SIZE  (BALL_SIZE),
    .PADDLE_L_X (PADDLE_L_X),
    .PADDLE_R_X (PADDLE_R_X),
    .PADDLE_H   (PADDLE_H)
  ) u_collide (
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .dir_x      (ball_dir_x),
    .dir_y      (ball_dir_y),
    .hit_l      (hit_l),
    .hit_r      (hit_r),
    .miss_l     (miss_l),
    .miss_r     (miss_r),
    .bounce_top (bounce_top),
    .bounce_bot (bounce_bot)
  );

  assign ball_reset   = ctrl.ball_reset;
  assign ball_move_en = ctrl.ball_move_en;
  assign game_over    = ctrl.game_over;
  assign state        = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= S_IDLE;
      ctrl       <= ctrl_for(S_IDLE);
      frame_cnt  <= '0;
      ball_dir_x <= 1'b1;
      ball_dir_y <= 1'b1;
      score_l    <= '0;
      score_r    <= '0;
      winner     <= 1'b0;
      scorer     <= 1'b0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (start) begin
            cur       <= S_SERVE;
            ctrl      <= ctrl_for(S_SERVE);
            frame_cnt <= '0;
            score_l   <= '0;
            score_r   <= '0;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            if (frame_cnt == SERVE_LAST) begin
              cur       <= S_PLAY;
              ctrl      <= ctrl_for(S_PLAY);
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (bounce_top)      ball_dir_y <= 1'b1;
            else if (bounce_bot) ball_dir_y <= 1'b0;
            if (hit_l)      ball_dir_x <= 1'b1;
            else if (hit_r) ball_dir_x <= 1'b0;
            // scorer: 1 = right player took the point, 0 = left player
            if (miss_l) begin
              if (score_r != WIN) score_r <= score_r + 1'b1;
              scorer    <= 1'b1;
              cur       <= S_POINT;
              ctrl      <= ctrl_for(S_POINT);
              frame_cnt <= '0;
            end else if (miss_r) begin
              if (score_l != WIN) score_l <= score_l + 1'b1;
              scorer    <= 1'b0;
              cur       <= S_POINT;
              ctrl      <= ctrl_for(S_POINT);
              frame_cnt <= '0;
            end
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            if (frame_cnt == PAUSE_LAST) begin
              frame_cnt <= '0;
              if ((scorer ? score_r : score_l) == WIN) begin
                cur    <= S_GAME_OVER;
                ctrl   <= ctrl_for(S_GAME_OVER);
                winner <= scorer;
              end else begin
                // Serve toward the player who conceded, alternating vertical direction.
                cur        <= S_SERVE;
                ctrl       <= ctrl_for(S_SERVE);
                ball_dir_x <= ~scorer;
                ball_dir_y <= ~ball_dir_y;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        S_GAME_OVER: begin
          if (start) begin
            cur       <= S_SERVE;
            ctrl      <= ctrl_for(S_SERVE);
            frame_cnt <= '0;
            score_l   <= '0;
            score_r   <= '0;
            winner    <= 1'b0;
          end
        end
        default: begin
          cur       <= S_IDLE;
          ctrl      <= ctrl_for(S_IDLE);
          frame_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a game-rules model is checked every cycle,
// and hand-computed expectations pin key points of the game flow.
module tb_pong_game_ctrl;

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;
  localparam int SERVE_N = 60, PAUSE_N = 90, WIN_N = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ball_x = 10'd320;
  logic [9:0] ball_y = 10'd240;
  logic [9:0] paddle_l_y = 10'd80;
  logic [9:0] paddle_r_y = 10'd80;
  logic       ball_reset, ball_move_en, ball_dir_x, ball_dir_y, game_over, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  pong_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .paddle_l_y   (paddle_l_y),
    .paddle_r_y   (paddle_r_y),
    .ball_reset   (ball_reset),
    .ball_move_en (ball_move_en),
    .ball_dir_x   (ball_dir_x),
    .ball_dir_y   (ball_dir_y),
    .score_l      (score_l),
    .score_r      (score_r),
    .game_over    (game_over),
    .winner       (winner),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Game-rules model: phase, frames remaining in the phase, scores, directions.
  int m_mode = M_IDLE, m_left = 0, m_sl = 0, m_sr = 0;
  int m_dx = 1, m_dy = 1, m_win = 0, m_scorer = 0;
  bit m_valid = 0;

  always @(posedge clk) begin : model
    int bx, by, pl, pr, ndx, ndy;
    bit lhit, rhit;
    bx = int'(ball_x); by = int'(ball_y); pl = int'(paddle_l_y); pr = int'(paddle_r_y);
    if (reset) begin
      m_mode = M_IDLE; m_left = 0; m_sl = 0; m_sr = 0;
      m_dx = 1; m_dy = 1; m_win = 0; m_scorer = 0; m_valid = 1;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_sl = 0; m_sr = 0; m_mode = M_SERVE; m_left = SERVE_N;
        end
        M_SERVE: if (frame_tick) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_PLAY;
        end
        M_PLAY: if (frame_tick) begin
          ndx = m_dx; ndy = m_dy;
          if (m_dy == 0 && by == 0) ndy = 1;
          if (m_dy == 1 && by >= 480 - 8) ndy = 0;
          lhit = (m_dx == 0) && (bx <= 16) && (by + 8 > pl) && (by < pl + 64);
          rhit = (m_dx == 1) && (bx + 8 >= 624) && (by + 8 > pr) && (by < pr + 64);
          if (lhit) ndx = 1;
          if (rhit) ndx = 0;
          if (m_dx == 0 && bx == 0 && !lhit) begin
            if (m_sr < WIN_N) m_sr = m_sr + 1;
            m_scorer = 1; m_mode = M_POINT; m_left = PAUSE_N;
          end
          if (m_dx == 1 && bx >= 640 - 8 && !rhit) begin
            if (m_sl < WIN_N) m_sl = m_sl + 1;
            m_scorer = 0; m_mode = M_POINT; m_left = PAUSE_N;
          end
          m_dx = ndx; m_dy = ndy;
        end
        M_POINT: if (frame_tick) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if ((m_scorer == 1 ? m_sr : m_sl) == WIN_N) begin
              m_mode = M_OVER; m_win = m_scorer;
            end else begin
              m_mode = M_SERVE; m_left = SERVE_N;
              m_dx = (m_scorer == 1) ? 0 : 1;
              m_dy = 1 - m_dy;
            end
          end
        end
        M_OVER: if (start) begin
          m_sl = 0; m_sr = 0; m_win = 0; m_mode = M_SERVE; m_left = SERVE_N;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    logic [16:0] act, exp_v;
    if (m_valid) begin
      act = {state, ball_reset, ball_move_en, ball_dir_x, ball_dir_y,
             score_l, score_r, game_over, winner};
      exp_v = {3'(m_mode), (m_mode == M_IDLE || m_mode == M_SERVE || m_mode == M_OVER),
               (m_mode == M_PLAY), 1'(m_dx), 1'(m_dy), 4'(m_sl), 4'(m_sr),
               (m_mode == M_OVER), 1'(m_win)};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("[TB] FAIL cycle_model at %0t: got %05h, expected %05h", $time, act, exp_v);
      end
    end
  end

  task automatic applyStimulus(input logic tick, input logic st);
    @(negedge clk);
    frame_tick = tick;
    start = st;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
  endtask

  task automatic setBall(input int x, input int y);
    ball_x = 10'(x);
    ball_y = 10'(y);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_ball_reset", int'(ball_reset), 1);
    checkOutput("reset_move_en", int'(ball_move_en), 0);
    checkOutput("reset_dirs", int'({ball_dir_x, ball_dir_y}), 3);
    checkOutput("reset_over_winner", int'({game_over, winner}), 0);

    // Start coincides with a frame tick; that tick must not count toward the serve.
    applyStimulus(1'b1, 1'b1);
    checkOutput("start_to_serve", int'(state), 1);
    frames(59);
    checkOutput("serve_after_59", int'(state), 1);
    frames(1);
    checkOutput("play_state", int'(state), 2);
    checkOutput("play_ctrl", int'({ball_reset, ball_move_en}), 1);
    checkOutput("play_dirs", int'({ball_dir_x, ball_dir_y}), 3);

    paddle_l_y = 10'd80; paddle_r_y = 10'd80;
    setBall(616, 100); applyStimulus(1'b1, 1'b0);
    checkOutput("right_hit_dx", int'(ball_dir_x), 0);
    setBall(16, 72); applyStimulus(1'b1, 1'b0);
    checkOutput("left_edge_nohit_dx", int'(ball_dir_x), 0);
    setBall(16, 100); applyStimulus(1'b1, 1'b0);
    checkOutput("left_hit_dx", int'(ball_dir_x), 1);
    checkOutput("hit_scores", int'({score_l, score_r}), 0);

    setBall(320, 471); applyStimulus(1'b1, 1'b0);
    checkOutput("no_bottom_471", int'(ball_dir_y), 1);
    setBall(320, 472); applyStimulus(1'b1, 1'b0);
    checkOutput("bottom_bounce", int'(ball_dir_y), 0);
    setBall(320, 0); applyStimulus(1'b1, 1'b0);
    checkOutput("top_bounce", int'(ball_dir_y), 1);

    setBall(616, 100); applyStimulus(1'b1, 1'b0);
    setBall(0, 300); applyStimulus(1'b1, 1'b0);
    checkOutput("left_miss_score_r", int'(score_r), 1);
    checkOutput("left_miss_state", int'(state), 3);
    checkOutput("point_ctrl", int'({ball_reset, ball_move_en}), 0);
    setBall(320, 240);
    frames(89);
    checkOutput("point_after_89", int'(state), 3);
    frames(1);
    checkOutput("reserve_state", int'(state), 1);
    checkOutput("reserve_dirs", int'({ball_dir_x, ball_dir_y}), 0);

    frames(60);
    paddle_l_y = 10'd0;
    setBall(16, 0); applyStimulus(1'b1, 1'b0);
    checkOutput("hit_and_top_dirs", int'({ball_dir_x, ball_dir_y}), 3);
    paddle_l_y = 10'd80;
    setBall(632, 472); applyStimulus(1'b1, 1'b0);
    checkOutput("miss_bottom_dy", int'(ball_dir_y), 0);
    checkOutput("miss_bottom_score_l", int'(score_l), 1);
    checkOutput("miss_bottom_state", int'(state), 3);
    setBall(320, 240);
    frames(90);
    checkOutput("serve_right_dirs", int'({ball_dir_x, ball_dir_y}), 3);

    for (int k = 0; k < 7; k++) begin
      frames(60);
      setBall(632, 300); applyStimulus(1'b1, 1'b0);
      setBall(320, 240);
      frames(90);
    end
    checkOutput("score_l_8", int'(score_l), 8);
    checkOutput("score_r_kept", int'(score_r), 1);

    frames(60);
    setBall(632, 300); applyStimulus(1'b1, 1'b0);
    checkOutput("score_l_9", int'(score_l), 9);
    setBall(320, 240);
    frames(89);
    checkOutput("final_point_wait", int'(state), 3);
    frames(1);
    checkOutput("game_over_state", int'(state), 4);
    checkOutput("game_over_flag", int'(game_over), 1);
    checkOutput("winner_left", int'(winner), 0);
    checkOutput("game_over_ball_reset", int'(ball_reset), 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("game_over_holds", int'(state), 4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("restart_state", int'(state), 1);
    checkOutput("restart_scores", int'({score_l, score_r}), 0);
    checkOutput("restart_over", int'({game_over, winner}), 0);

    frames(60);
    applyStimulus(1'b0, 1'b1);
    checkOutput("start_ignored_in_play", int'(state), 2);

    // Reset together with a frame tick that would otherwise score a right miss.
    setBall(632, 300);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("sync_reset_state", int'(state), 0);
    checkOutput("sync_reset_ctrl", int'({ball_reset, ball_move_en, game_over}), 4);
    checkOutput("sync_reset_dirs", int'({ball_dir_x, ball_dir_y}), 3);
    checkOutput("sync_reset_scores", int'({score_l, score_r}), 0);
    reset = 1'b0;
    setBall(320, 240);
    frames(2);
    checkOutput("idle_after_reset", int'(state), 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
